sha3_lane_packer: RTL
=====================

// Module: sha3_lane_packer
// PURPOSE
//  Downstream consumer of the 128-in/64-out bus FIFO in the SHA3 burst master. Pops 64-bit
//  lanes, packs them into RATE_LANES-lane rate blocks, applies SHA3 padding (0x06..0x80)
//  after the last message lane, and hands each block to the Keccak core with valid/ready.
//  Messages are always a whole number of 64-bit lanes.
// PARAMETERS
//  RATE_LANES  17  lanes per rate block (17 = SHA3-256, 1088-bit rate)
//  LANE_W      64  lane width in bits; fixed at 64, present for package consistency
// PORTS
//  clk             in   1                 system clock
//  rst             in   1                 reset; one clock, asynchronous, active-high
//  start           in   1                 begin message; sampled only in IDLE
//  msg_lanes       in   16                total message length in lanes, sampled with start
//  fifo_read_data  in   64                FIFO head word; valid whenever fifo_empty=0
//  fifo_empty      in   1                 FIFO empty flag
//  fifo_read       out  1                 pop; the FIFO head is consumed this cycle
//  block_data      out  RATE_LANES*64     lane i at [64*i+63:64*i]
//  block_valid     out  1                 block_data presented to the Keccak core
//  block_ready     in   1                 core accepts the block when valid&ready
//  block_last      out  1                 presented block is the final padded block
//  busy            out  1                 high from start accept until DONE exits
//  done            out  1                 one-cycle pulse after the last block is accepted
// BEHAVIOUR
//  Reset: state=IDLE, lane_idx=0, remaining=0, lane regs=0, last_flag=0; outputs
//   fifo_read, block_valid, block_last, busy, done = 0; block_data = 0.
//  FSM states: IDLE, FILL, PAD, PRESENT, DONE.
//  IDLE: start=1 -> remaining<=msg_lanes, lane_idx<=0, busy<=1. Next state is FILL if
//   msg_lanes!=0, else PAD. start is ignored in every other state.
//  FILL: fifo_read = (state==FILL) & !fifo_empty, combinational. On a pop:
//   lane[lane_idx]<=fifo_read_data, lane_idx++, remaining--.
//   Max rate is one lane/cycle; an empty FIFO stalls with no pop.
//   If the pop is at lane_idx==RATE_LANES-1 -> PRESENT with last_flag=0, even when remaining
//   reaches 0 (that block is full, so a padding-only block follows).
//   Else if remaining reaches 0 -> PAD.
//  PAD, one cycle: for every lane j>=lane_idx, lane[j]<=(j==lane_idx ? 64'h06 : 0);
//   lane[RATE_LANES-1][63] is ORed to 1. If lane_idx==RATE_LANES-1 that lane becomes
//   64'h8000_0000_0000_0006. Then last_flag<=1 -> PRESENT.
//  PRESENT: block_valid=1, block_last=last_flag. block_data is held stable and no pops occur.
//   valid&ready -> if last_flag go to DONE; else lane_idx<=0 and go to FILL
//   (remaining!=0) or PAD (remaining==0).
//  DONE: done=1 for one cycle, busy<=0, last_flag<=0 -> IDLE.
//  Lane registers below lane_idx are always overwritten by FILL before PAD, so no per-block
//   clear is needed.
//  block_valid never deasserts without a handshake.
//  rst asserted mid-message: immediate return to reset values. Lanes already popped are lost;
//   the FIFO must be flushed by its own reset. The bench drives both resets together.
//  Latency for a block of N data lanes with a non-empty FIFO: N FILL cycles, +1 PAD if final,
//   then PRESENT; block_valid rises on the cycle after the last pop or PAD.
//  Arithmetic: lane_idx is $clog2(RATE_LANES) bits and never exceeds RATE_LANES-1;
//   remaining is 16-bit unsigned, decrements only on a pop and never underflows.
// STRUCTURE
//  sha3_pkg holds: LANE_W=64, RATE_LANES_SHA3_256=17, PAD_DOMAIN=64'h06,
//  PAD_FINAL_BIT=63, and the packer state encoding (IDLE/FILL/PAD/PRESENT/DONE).
//  Single module, no sub-module: the lane register array, two counters and the FSM are all
//  in one file.
// TESTING
//  1 msg_lanes=0, FIFO empty -> one block: lane0=64'h06, lane16=64'h8000_0000_0000_0000,
//    lanes 1..15=0, block_last=1; zero fifo_read; done pulses once.
//  2 msg_lanes=3, FIFO holds 1,2,3 -> lanes0..2=1,2,3, lane3=64'h06, lane16 bit63 set,
//    last=1; exactly 3 pops on 3 consecutive cycles.
//  3 msg_lanes=16 (0x10..0x1F) -> lane15=0x1F, lane16=64'h8000_0000_0000_0006, one block,
//    last=1.
//  4 msg_lanes=17 -> block1: 17 data lanes, last=0; block2: lane0=0x06,
//    lane16=64'h8000..0, last=1; 17 pops total.
//  5 block_ready held low 10 cycles with the FIFO non-empty -> block_data stable and no pops.
//    FIFO empty for 4 cycles mid-FILL -> fifo_read=0 throughout and the resumed lane order
//    is intact.
//  6 rst pulsed at lane_idx=5 of msg_lanes=20 -> next edge: block_valid=0, busy=0, state
//    IDLE; a new start with msg_lanes=1 then completes normally.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants and packer state encoding for the SHA3 burst master datapath.
package sha3_pkg;
    localparam int          LANE_W              = 64;
    localparam int          RATE_LANES_SHA3_256 = 17;
    localparam logic [63:0] PAD_DOMAIN          = 64'h06;
    localparam int          PAD_FINAL_BIT       = 63;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_PAD     = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } packer_state_t;
endpackage

// File: rtl/sha3_lane_packer.sv
// Packs 64-bit FIFO lanes into SHA3 rate blocks, appends 0x06..0x80 padding after the
// last message lane, and presents each block to the Keccak core with valid/ready.
module sha3_lane_packer #(
    parameter int RATE_LANES = 17,
    parameter int LANE_W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  msg_lanes,
    input  logic [LANE_W-1:0]            fifo_read_data,
    input  logic                         fifo_empty,
    output logic                         fifo_read,
    output logic [RATE_LANES*LANE_W-1:0] block_data,
    output logic                         block_valid,
    input  logic                         block_ready,
    output logic                         block_last,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   fsm_state
);
    import sha3_pkg::*;

    localparam int               IDX_W    = $clog2(RATE_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    packer_state_t     state, state_next;
    logic [IDX_W-1:0]  lane_idx;
    logic [15:0]       remaining;
    logic [LANE_W-1:0] lanes     [RATE_LANES];
    logic [LANE_W-1:0] pad_lanes [RATE_LANES];
    logic              last_flag;
    logic              pop;

    // Handshake: the core takes block_data on any cycle where block_valid and block_ready
    // are both high; block_valid stays high and block_data stays frozen until that happens.
    assign pop         = (state == ST_FILL) && !fifo_empty;
    assign fifo_read   = pop;
    assign block_valid = (state == ST_PRESENT);
    assign block_last  = block_valid && last_flag;
    assign done        = (state == ST_DONE);
    assign fsm_state   = state;

    for (genvar g = 0; g < RATE_LANES; g++) begin : g_block
        assign block_data[LANE_W*g +: LANE_W] = lanes[g];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (start) state_next = (msg_lanes != 16'd0) ? ST_FILL : ST_PAD;
            ST_FILL: begin
                // A pop into the last lane always presents a full block, even when it
                // was the final message lane; padding then goes into a block of its own.
                if (pop) begin
                    if (lane_idx == LAST_IDX)     state_next = ST_PRESENT;
                    else if (remaining == 16'd1)  state_next = ST_PAD;
                end
            end
            ST_PAD:     state_next = ST_PRESENT;
            ST_PRESENT: begin
                if (block_ready) begin
                    if (last_flag)                state_next = ST_DONE;
                    else if (remaining != 16'd0)  state_next = ST_FILL;
                    else                          state_next = ST_PAD;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Lanes below lane_idx already hold message data; everything from lane_idx up is padding.
    always_comb begin
        for (int j = 0; j < RATE_LANES; j++) begin
            pad_lanes[j] = lanes[j];
            if (j >= int'(lane_idx)) pad_lanes[j] = (j == int'(lane_idx)) ? PAD_DOMAIN : '0;
        end
        pad_lanes[RATE_LANES-1][PAD_FINAL_BIT] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_idx  <= '0;
            remaining <= '0;
            last_flag <= 1'b0;
            busy      <= 1'b0;
            for (int j = 0; j < RATE_LANES; j++) lanes[j] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= msg_lanes;
                        lane_idx  <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (pop) begin
                        lanes[lane_idx] <= fifo_read_data;
                        remaining       <= remaining - 16'd1;
                        if (lane_idx != LAST_IDX) lane_idx <= lane_idx + IDX_W'(1);
                    end
                end
                ST_PAD: begin
                    lanes     <= pad_lanes;
                    last_flag <= 1'b1;
                end
                ST_PRESENT: begin
                    if (block_ready && !last_flag) lane_idx <= '0;
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    last_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
